// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared fetch FSM states and fetch constants.
package fetch_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
    localparam int PC_INCR = 4;
    localparam int INSTR_W = 32;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC select (jump > branch > sequential), word aligned.
module fetch_next_pc
    import fetch_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             commit,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc_next
);
    logic [WIDTH-1:0] sel;
    always_comb begin
        sel = !commit      ? pc :
              jump         ? jump_target :
              branch_taken ? branch_target :
                             pc + WIDTH'(PC_INCR);
        pc_next = sel & ~WIDTH'(3);
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch FSM issuing imem requests, holding the instruction until
// decode commits it, and flagging a sticky fault when memory never acknowledges.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   pc_next,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump,
    input  logic               branch_taken,
    input  logic [WIDTH-1:0]   jump_target,
    input  logic [WIDTH-1:0]   branch_target,
    output logic               fetch_fault
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               commit;
    logic [WIDTH-1:0]   np;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    // Counter is zero in every state but REQ, so each REQ entry starts a fresh wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD:    state_d = instr_ready ? REQ : HOLD;
            default: state_d = FAULT;
        endcase
    end

    assign commit      = state_q == HOLD && instr_ready;
    assign imem_req    = state_q == REQ && !RST;
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = state_q == HOLD;
    assign fetch_fault = state_q == FAULT;
    assign pc_next     = RST ? '0 : np;

    fetch_next_pc #(.WIDTH(WIDTH)) u_next_pc (
        .pc            (pc),
        .commit        (commit),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .pc_next       (np)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch, hold, redirect, wrap, timeout and reset.
module tb_fetch_sequencer;
    logic        CLK = 0;
    logic        RST;
    logic [31:0] pc, pc_next, imem_addr, imem_rdata, instr, jump_target, branch_target;
    logic        imem_req, imem_ack, instr_valid, instr_ready, jump, branch_taken, fetch_fault;
    int          errs = 0;
    int          checks = 0;

    fetch_sequencer #(.WIDTH(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .pc(pc), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .jump(jump), .branch_taken(branch_taken),
        .jump_target(jump_target), .branch_target(branch_target),
        .fetch_fault(fetch_fault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST = 1; pc = 32'h40; imem_ack = 0; imem_rdata = 0; instr_ready = 0;
        jump = 0; branch_taken = 0; jump_target = 0; branch_target = 0;
        step(); step();
        #1;
        chk("rst_pc_next", pc_next, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_instr", instr, 0);

        RST = 0; #1;
        chk("idle_req", imem_req, 0);
        step();
        pc = 0; imem_ack = 1; imem_rdata = 32'h20080005; #1;
        chk("req1_req", imem_req, 1);
        chk("req1_addr", imem_addr, 0);
        chk("req1_valid", instr_valid, 0);
        step();
        imem_ack = 0; imem_rdata = 32'hFFFFFFFF; #1;
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, 32'h20080005);

        // stalled HOLD: redirect inputs must be ignored without commit
        pc = 32'h10; jump = 1; jump_target = 32'h100; imem_ack = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_instr", instr, 32'h20080005);
            chk("stall_pc_next", pc_next, 32'h10);
            chk("stall_valid", instr_valid, 1);
            step();
        end
        imem_ack = 0; jump = 0; instr_ready = 1; #1;
        chk("commit_seq", pc_next, 32'h14);
        step();
        instr_ready = 0; pc = 32'h14; imem_ack = 1; imem_rdata = 32'hAAAA0001; #1;
        chk("req2_req", imem_req, 1);
        chk("req2_valid", instr_valid, 0);
        chk("req2_pc_hold", pc_next, 32'h14);
        step();
        imem_ack = 0;
        instr_ready = 1; jump = 1; jump_target = 32'h100;
        branch_taken = 1; branch_target = 32'h200; #1;
        chk("jump_prio", pc_next, 32'h100);
        jump = 0; branch_target = 32'h203; #1;
        chk("branch_align", pc_next, 32'h200);
        jump = 1; jump_target = 32'h107; #1;
        chk("jump_align", pc_next, 32'h104);
        jump = 0; branch_taken = 0; pc = 32'hFFFFFFFC; #1;
        chk("wrap", pc_next, 32'h0);
        chk("req2_instr", instr, 32'hAAAA0001);
        step();

        // no ack: four REQ cycles then FAULT
        instr_ready = 0; pc = 32'h20;
        step(); step(); step(); #1;
        chk("to_req4", imem_req, 1);
        chk("to_nofault", fetch_fault, 0);
        step(); #1;
        chk("to_fault", fetch_fault, 1);
        chk("to_req0", imem_req, 0);
        chk("to_valid0", instr_valid, 0);
        imem_ack = 1; imem_rdata = 32'h12345678; instr_ready = 1; jump = 1; jump_target = 32'h300;
        step(); step(); #1;
        chk("fault_sticky", fetch_fault, 1);
        chk("fault_valid", instr_valid, 0);
        chk("fault_instr", instr, 32'hAAAA0001);
        chk("fault_pc_hold", pc_next, 32'h20);
        chk("fault_req", imem_req, 0);
        imem_ack = 0; instr_ready = 0; jump = 0;
        RST = 1; step();
        RST = 0; #1;
        chk("clr_fault", fetch_fault, 0);
        chk("clr_instr", instr, 0);

        // reset mid-REQ with a simultaneous ack
        step();
        #1;
        chk("req3_req", imem_req, 1);
        RST = 1; imem_ack = 1; imem_rdata = 32'hDEADBEEF; #1;
        chk("rst_mid_pc", pc_next, 0);
        chk("rst_mid_req", imem_req, 0);
        step();
        RST = 0; imem_ack = 0; #1;
        chk("rst_mid_valid", instr_valid, 0);
        chk("rst_mid_instr", instr, 0);
        chk("rst_mid_idle", imem_req, 0);
        step(); #1;
        chk("rst_mid_req_again", imem_req, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
